// File: rtl/bp_cfg_boot_sequencer_pkg.sv
// Shared cfg link definitions: register offsets, boot sequencer state encoding,
// and the write beat carried on the link.
package bp_cfg_boot_sequencer_pkg;

  localparam int bp_cfg_addr_width_gp = 16;
  localparam int bp_cfg_data_width_gp = 64;
  localparam int bp_cfg_ucode_max_gp  = 4096;

  localparam logic [15:0] bp_cfg_reg_freeze_gp      = 16'h0002;
  localparam logic [15:0] bp_cfg_reg_core_id_gp     = 16'h0005;
  localparam logic [15:0] bp_cfg_reg_did_gp         = 16'h0007;
  localparam logic [15:0] bp_cfg_reg_cord_gp        = 16'h0008;
  localparam logic [15:0] bp_cfg_reg_icache_mode_gp = 16'h0022;
  localparam logic [15:0] bp_cfg_reg_dcache_mode_gp = 16'h0043;
  localparam logic [15:0] bp_cfg_reg_npc_gp         = 16'h0040;
  localparam logic [15:0] bp_cfg_reg_cce_mode_gp    = 16'h0081;
  localparam logic [15:0] bp_cfg_reg_cce_ucode_gp   = 16'h8000;

  typedef enum logic [3:0] {
    e_boot_idle,
    e_boot_freeze,
    e_boot_core_id,
    e_boot_did,
    e_boot_cord,
    e_boot_icache_mode,
    e_boot_dcache_mode,
    e_boot_npc,
    e_boot_ucode,
    e_boot_cce_mode,
    e_boot_unfreeze,
    e_boot_done
  } bp_cfg_boot_state_e;

  typedef struct packed {
    logic [bp_cfg_addr_width_gp-1:0] addr;
    logic [bp_cfg_data_width_gp-1:0] data;
  } bp_cfg_write_beat_s;

  // Microcode words live in a 4K window starting at the CCE ucode base.
  function automatic logic [15:0] bp_cfg_ucode_addr(input logic [11:0] idx);
    return bp_cfg_reg_cce_ucode_gp | {4'h0, idx};
  endfunction

endpackage

// File: rtl/bp_cfg_boot_sequencer.sv
// Config link master that walks one tile from reset to run with a fixed write
// order: freeze, identity, cache modes, NPC, CCE microcode, CCE mode, unfreeze.
//
// Link handshake: cfg_v_o is held with cfg_addr_o/cfg_data_o stable until the
// cycle in which cfg_v_o & cfg_ready_i; the write is taken on that clock edge
// and the next write (if any) is presented the following cycle.
module bp_cfg_boot_sequencer
  import bp_cfg_boot_sequencer_pkg::*;
#(
  parameter int cfg_addr_width_p  = 16,
  parameter int cfg_data_width_p  = 64,
  parameter int vaddr_width_p     = 39,
  parameter int core_id_width_p   = 6,
  parameter int did_width_p       = 3,
  parameter int cord_width_p      = 8,
  parameter int ucode_len_width_p = 13
) (
  input  logic                         clk_i,
  input  logic                         reset_i,
  input  logic                         start_i,
  input  logic [vaddr_width_p-1:0]     boot_pc_i,
  input  logic [core_id_width_p-1:0]   core_id_i,
  input  logic [did_width_p-1:0]       did_i,
  input  logic [cord_width_p-1:0]      cord_i,
  input  logic [1:0]                   icache_mode_i,
  input  logic [1:0]                   dcache_mode_i,
  input  logic                         cce_mode_i,
  input  logic [ucode_len_width_p-1:0] ucode_len_i,
  output logic [11:0]                  ucode_addr_o,
  input  logic [cfg_data_width_p-1:0]  ucode_data_i,
  output logic                         cfg_v_o,
  output logic [cfg_addr_width_p-1:0]  cfg_addr_o,
  output logic [cfg_data_width_p-1:0]  cfg_data_o,
  input  logic                         cfg_ready_i,
  output logic                         busy_o,
  output logic                         done_o
);

  bp_cfg_boot_state_e state_q, state_d;
  bp_cfg_write_beat_s beat_q, beat_d;
  logic               cfg_v_q, cfg_v_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [11:0]        idx_q, idx_d;
  logic [12:0]        len_q, len_d;

  logic [vaddr_width_p-1:0]   npc_q, npc_d;
  logic [core_id_width_p-1:0] core_id_q, core_id_d;
  logic [did_width_p-1:0]     did_q, did_d;
  logic [cord_width_p-1:0]    cord_q, cord_d;
  logic [1:0]                 icache_mode_q, icache_mode_d;
  logic [1:0]                 dcache_mode_q, dcache_mode_d;
  logic                       cce_mode_q, cce_mode_d;

  logic accept;
  logic ucode_last;

  function automatic bp_cfg_boot_state_e next_state(input bp_cfg_boot_state_e s,
                                                    input logic len_zero,
                                                    input logic last);
    bp_cfg_boot_state_e n;
    n = e_boot_idle;
    case (s)
      e_boot_freeze:      n = e_boot_core_id;
      e_boot_core_id:     n = e_boot_did;
      e_boot_did:         n = e_boot_cord;
      e_boot_cord:        n = e_boot_icache_mode;
      e_boot_icache_mode: n = e_boot_dcache_mode;
      e_boot_dcache_mode: n = e_boot_npc;
      e_boot_npc:         n = len_zero ? e_boot_cce_mode : e_boot_ucode;
      e_boot_ucode:       n = last ? e_boot_cce_mode : e_boot_ucode;
      e_boot_cce_mode:    n = e_boot_unfreeze;
      e_boot_unfreeze:    n = e_boot_done;
      default:            n = e_boot_idle;
    endcase
    return n;
  endfunction

  // Beat presented while in state s; ucode data is taken live from the ROM port.
  function automatic bp_cfg_write_beat_s beat_for(input bp_cfg_boot_state_e s,
                                                  input logic [11:0] idx);
    bp_cfg_write_beat_s b;
    b = '0;
    case (s)
      e_boot_freeze: begin
        b.addr = bp_cfg_reg_freeze_gp;
        b.data = 64'd1;
      end
      e_boot_core_id: begin
        b.addr = bp_cfg_reg_core_id_gp;
        b.data = bp_cfg_data_width_gp'(core_id_q);
      end
      e_boot_did: begin
        b.addr = bp_cfg_reg_did_gp;
        b.data = bp_cfg_data_width_gp'(did_q);
      end
      e_boot_cord: begin
        b.addr = bp_cfg_reg_cord_gp;
        b.data = bp_cfg_data_width_gp'(cord_q);
      end
      e_boot_icache_mode: begin
        b.addr = bp_cfg_reg_icache_mode_gp;
        b.data = bp_cfg_data_width_gp'(icache_mode_q);
      end
      e_boot_dcache_mode: begin
        b.addr = bp_cfg_reg_dcache_mode_gp;
        b.data = bp_cfg_data_width_gp'(dcache_mode_q);
      end
      e_boot_npc: begin
        b.addr = bp_cfg_reg_npc_gp;
        b.data = bp_cfg_data_width_gp'(npc_q);
      end
      e_boot_ucode: begin
        b.addr = bp_cfg_ucode_addr(idx);
        b.data = '0;
      end
      e_boot_cce_mode: begin
        b.addr = bp_cfg_reg_cce_mode_gp;
        b.data = bp_cfg_data_width_gp'(cce_mode_q);
      end
      e_boot_unfreeze: begin
        b.addr = bp_cfg_reg_freeze_gp;
        b.data = '0;
      end
      default: b = '0;
    endcase
    return b;
  endfunction

  always_comb begin
    state_d       = state_q;
    beat_d        = beat_q;
    cfg_v_d       = cfg_v_q;
    busy_d        = busy_q;
    done_d        = done_q;
    idx_d         = idx_q;
    len_d         = len_q;
    npc_d         = npc_q;
    core_id_d     = core_id_q;
    did_d         = did_q;
    cord_d        = cord_q;
    icache_mode_d = icache_mode_q;
    dcache_mode_d = dcache_mode_q;
    cce_mode_d    = cce_mode_q;
    accept        = cfg_v_q & cfg_ready_i;
    ucode_last    = ({1'b0, idx_q} == (len_q - 13'd1));

    case (state_q)
      e_boot_idle, e_boot_done: begin
        if (start_i) begin
          npc_d         = boot_pc_i;
          core_id_d     = core_id_i;
          did_d         = did_i;
          cord_d        = cord_i;
          icache_mode_d = icache_mode_i;
          dcache_mode_d = dcache_mode_i;
          cce_mode_d    = cce_mode_i;
          len_d         = (ucode_len_i > ucode_len_width_p'(bp_cfg_ucode_max_gp))
                          ? 13'(bp_cfg_ucode_max_gp) : 13'(ucode_len_i);
          idx_d         = '0;
          state_d       = e_boot_freeze;
          beat_d        = beat_for(e_boot_freeze, '0);
          cfg_v_d       = 1'b1;
          busy_d        = 1'b1;
          done_d        = 1'b0;
        end else if (state_q == e_boot_done) begin
          state_d = e_boot_idle;
        end
      end
      default: begin
        if (accept) begin
          // The 12-bit index wraps harmlessly after the 4096th word.
          if (state_q == e_boot_ucode) idx_d = idx_q + 12'd1;
          state_d = next_state(state_q, (len_q == 13'd0), ucode_last);
          beat_d  = beat_for(state_d, idx_d);
          if (state_d == e_boot_done) begin
            cfg_v_d = 1'b0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q       <= e_boot_idle;
      beat_q        <= '0;
      cfg_v_q       <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      idx_q         <= '0;
      len_q         <= '0;
      npc_q         <= '0;
      core_id_q     <= '0;
      did_q         <= '0;
      cord_q        <= '0;
      icache_mode_q <= '0;
      dcache_mode_q <= '0;
      cce_mode_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      beat_q        <= beat_d;
      cfg_v_q       <= cfg_v_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      idx_q         <= idx_d;
      len_q         <= len_d;
      npc_q         <= npc_d;
      core_id_q     <= core_id_d;
      did_q         <= did_d;
      cord_q        <= cord_d;
      icache_mode_q <= icache_mode_d;
      dcache_mode_q <= dcache_mode_d;
      cce_mode_q    <= cce_mode_d;
    end
  end

  assign ucode_addr_o = idx_q;
  assign cfg_v_o      = cfg_v_q;
  assign cfg_addr_o   = cfg_addr_width_p'(beat_q.addr);
  assign cfg_data_o   = (state_q == e_boot_ucode) ? ucode_data_i
                                                  : cfg_data_width_p'(beat_q.data);
  assign busy_o       = busy_q;
  assign done_o       = done_q;

endmodule

// File: tb/tb_bp_cfg_boot_sequencer.sv
// Bench for bp_cfg_boot_sequencer: scenario tasks drive boots, a negedge monitor
// scores every accepted cfg write against an ordered expected queue.
module tb_bp_cfg_boot_sequencer;

  logic        clk;
  logic        reset_i;
  logic        start_i;
  logic [38:0] boot_pc_i;
  logic [5:0]  core_id_i;
  logic [2:0]  did_i;
  logic [7:0]  cord_i;
  logic [1:0]  icache_mode_i;
  logic [1:0]  dcache_mode_i;
  logic        cce_mode_i;
  logic [12:0] ucode_len_i;
  logic [11:0] ucode_addr_o;
  logic [63:0] ucode_data_i;
  logic        cfg_v_o;
  logic [15:0] cfg_addr_o;
  logic [63:0] cfg_data_o;
  logic        cfg_ready_i;
  logic        busy_o;
  logic        done_o;

  int n_cmp;
  int n_fail;

  logic [79:0] exp_q[$];
  int          n_writes;
  logic        saw_ucode;
  logic [15:0] last_ucode_addr;

  int          obs_done_cyc;
  int          obs_stall_bad;
  logic        obs_first_v;
  logic        obs_busy_c1;
  logic        obs_done_c1;

  logic [31:0] rom_salt;

  // ---------------- clock / reset / DUT ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [63:0] rom_word(input logic [11:0] a);
    return {rom_salt, 20'h0, a};
  endfunction

  assign ucode_data_i = rom_word(ucode_addr_o);

  bp_cfg_boot_sequencer dut (
    .clk_i         (clk),
    .reset_i       (reset_i),
    .start_i       (start_i),
    .boot_pc_i     (boot_pc_i),
    .core_id_i     (core_id_i),
    .did_i         (did_i),
    .cord_i        (cord_i),
    .icache_mode_i (icache_mode_i),
    .dcache_mode_i (dcache_mode_i),
    .cce_mode_i    (cce_mode_i),
    .ucode_len_i   (ucode_len_i),
    .ucode_addr_o  (ucode_addr_o),
    .ucode_data_i  (ucode_data_i),
    .cfg_v_o       (cfg_v_o),
    .cfg_addr_o    (cfg_addr_o),
    .cfg_data_o    (cfg_data_o),
    .cfg_ready_i   (cfg_ready_i),
    .busy_o        (busy_o),
    .done_o        (done_o)
  );

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    logic [79:0] got;
    logic [79:0] exp;
    if (!reset_i && cfg_v_o && cfg_ready_i) begin
      got = {cfg_addr_o, cfg_data_o};
      n_writes++;
      if (cfg_addr_o[15:12] == 4'h8) begin
        saw_ucode       = 1'b1;
        last_ucode_addr = cfg_addr_o;
      end
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL write_extra: got addr=%h data=%h, required no write", cfg_addr_o, cfg_data_o);
      end else begin
        exp = exp_q.pop_front();
        if (got !== exp) begin
          n_fail++;
          $display("FAIL write_order #%0d: got addr=%h data=%h, required addr=%h data=%h",
                   n_writes, got[79:64], got[63:0], exp[79:64], exp[63:0]);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic push_sequence(input int eff_len, input logic [5:0] cid, input logic [2:0] did,
                               input logic [7:0] cord, input logic [1:0] im, input logic [1:0] dm,
                               input logic [38:0] pc, input logic cm);
    exp_q.push_back({16'h0002, 64'd1});
    exp_q.push_back({16'h0005, {58'h0, cid}});
    exp_q.push_back({16'h0007, {61'h0, did}});
    exp_q.push_back({16'h0008, {56'h0, cord}});
    exp_q.push_back({16'h0022, {62'h0, im}});
    exp_q.push_back({16'h0043, {62'h0, dm}});
    exp_q.push_back({16'h0040, {25'h0, pc}});
    for (int k = 0; k < eff_len; k++) begin
      logic [11:0] a;
      a = 12'(k);
      exp_q.push_back({4'h8, a, rom_word(a)});
    end
    exp_q.push_back({16'h0081, {63'h0, cm}});
    exp_q.push_back({16'h0002, 64'd0});
  endtask

  task automatic drive_inputs(input int len_in, input logic [5:0] cid, input logic [38:0] pc);
    logic [2:0] did;
    logic [7:0] cord;
    logic [1:0] im;
    logic [1:0] dm;
    logic       cm;
    int         eff;
    did  = 3'($urandom_range(0, 7));
    cord = 8'($urandom_range(0, 255));
    im   = 2'($urandom_range(0, 3));
    dm   = 2'($urandom_range(0, 3));
    cm   = 1'($urandom_range(0, 1));
    boot_pc_i     = pc;
    core_id_i     = cid;
    did_i         = did;
    cord_i        = cord;
    icache_mode_i = im;
    dcache_mode_i = dm;
    cce_mode_i    = cm;
    ucode_len_i   = 13'(len_in);
    eff = (len_in > 4096) ? 4096 : len_in;
    push_sequence(eff, cid, did, cord, im, dm, pc, cm);
  endtask

  // Runs one boot; records latency and handshake observations for the caller.
  task automatic run_boot(input int len_in, input logic [5:0] cid, input logic [38:0] pc,
                          input int ready_pct, input int inject_cyc);
    logic        prev_stall;
    logic [79:0] prev_beat;
    drive_inputs(len_in, cid, pc);
    n_writes        = 0;
    saw_ucode       = 1'b0;
    last_ucode_addr = '0;
    obs_stall_bad   = 0;
    obs_done_cyc    = -1;
    prev_stall      = 1'b0;
    prev_beat       = '0;
    start_i = 1'b1;
    @(posedge clk);
    #1;
    start_i = 1'b0;
    for (int cyc = 1; cyc <= 20000; cyc++) begin
      if (cyc > 1) begin
        @(posedge clk);
        #1;
      end
      if (inject_cyc != 0 && cyc == inject_cyc) begin
        start_i   = 1'b1;
        core_id_i = ~cid;
      end else begin
        start_i = 1'b0;
      end
      cfg_ready_i = (ready_pct >= 100) ? 1'b1 : ($urandom_range(0, 99) < ready_pct);
      @(negedge clk);
      if (cyc == 1) begin
        obs_first_v = cfg_v_o;
        obs_busy_c1 = busy_o;
        obs_done_c1 = done_o;
      end
      if (prev_stall && !(cfg_v_o === 1'b1 && {cfg_addr_o, cfg_data_o} === prev_beat))
        obs_stall_bad++;
      prev_stall = cfg_v_o && !cfg_ready_i;
      prev_beat  = {cfg_addr_o, cfg_data_o};
      if (done_o === 1'b1) begin
        obs_done_cyc = cyc;
        break;
      end
    end
    start_i = 1'b0;
  endtask

  // ---------------- scenario tasks ----------------
  task automatic test_reset();
    reset_i = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_cmp++; if (cfg_v_o !== 1'b0) begin n_fail++; $display("FAIL reset_cfg_v: got %b required 0", cfg_v_o); end
    n_cmp++; if (cfg_addr_o !== 16'h0) begin n_fail++; $display("FAIL reset_cfg_addr: got %h required 0", cfg_addr_o); end
    n_cmp++; if (cfg_data_o !== 64'h0) begin n_fail++; $display("FAIL reset_cfg_data: got %h required 0", cfg_data_o); end
    n_cmp++; if (ucode_addr_o !== 12'h0) begin n_fail++; $display("FAIL reset_ucode_addr: got %h required 0", ucode_addr_o); end
    n_cmp++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b required 0", busy_o); end
    n_cmp++; if (done_o !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b required 0", done_o); end
    @(posedge clk);
    #1;
    reset_i = 1'b0;
  endtask

  task automatic test_basic();
    run_boot(4, 6'd3, 39'h0_8000_0000, 100, 0);
    n_cmp++; if (obs_first_v !== 1'b1) begin n_fail++; $display("FAIL basic_first_valid_c1: got %b required 1", obs_first_v); end
    n_cmp++; if (obs_busy_c1 !== 1'b1) begin n_fail++; $display("FAIL basic_busy_c1: got %b required 1", obs_busy_c1); end
    n_cmp++; if (obs_done_cyc != 14) begin n_fail++; $display("FAIL basic_done_cycle: got %0d required 14", obs_done_cyc); end
    n_cmp++; if (n_writes != 13) begin n_fail++; $display("FAIL basic_write_count: got %0d required 13", n_writes); end
    n_cmp++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL basic_missing_writes: got %0d left required 0", exp_q.size()); end
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_cmp++; if (done_o !== 1'b1) begin n_fail++; $display("FAIL basic_done_holds: got %b required 1", done_o); end
    n_cmp++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL basic_idle_busy: got %b required 0", busy_o); end
    n_cmp++; if (cfg_v_o !== 1'b0) begin n_fail++; $display("FAIL basic_idle_valid: got %b required 0", cfg_v_o); end
    @(posedge clk);
    #1;
  endtask

  task automatic test_len_zero();
    run_boot(0, 6'd17, 39'h12_3456_7890, 100, 0);
    n_cmp++; if (obs_done_cyc != 10) begin n_fail++; $display("FAIL len0_done_cycle: got %0d required 10", obs_done_cyc); end
    n_cmp++; if (n_writes != 9) begin n_fail++; $display("FAIL len0_write_count: got %0d required 9", n_writes); end
    n_cmp++; if (saw_ucode !== 1'b0) begin n_fail++; $display("FAIL len0_ucode_range: got %b required 0", saw_ucode); end
    n_cmp++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL len0_missing_writes: got %0d left required 0", exp_q.size()); end
  endtask

  task automatic test_stalls();
    run_boot(16, 6'd42, 39'h7f_0000_1000, 30, 0);
    n_cmp++; if (obs_done_cyc < 25) begin n_fail++; $display("FAIL stall_done_seen: got cycle %0d required >= 25", obs_done_cyc); end
    n_cmp++; if (obs_stall_bad != 0) begin n_fail++; $display("FAIL stall_stability: got %0d unstable cycles required 0", obs_stall_bad); end
    n_cmp++; if (n_writes != 25) begin n_fail++; $display("FAIL stall_write_count: got %0d required 25", n_writes); end
    n_cmp++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL stall_missing_writes: got %0d left required 0", exp_q.size()); end
  endtask

  task automatic test_saturate();
    run_boot(5000, 6'd9, 39'h00_0000_2000, 100, 0);
    n_cmp++; if (obs_done_cyc != 4106) begin n_fail++; $display("FAIL sat_done_cycle: got %0d required 4106", obs_done_cyc); end
    n_cmp++; if (n_writes != 4105) begin n_fail++; $display("FAIL sat_write_count: got %0d required 4105", n_writes); end
    n_cmp++; if (last_ucode_addr !== 16'h8fff) begin n_fail++; $display("FAIL sat_last_ucode_addr: got %h required 8fff", last_ucode_addr); end
    n_cmp++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL sat_missing_writes: got %0d left required 0", exp_q.size()); end
  endtask

  task automatic test_start_while_busy();
    run_boot(8, 6'd21, 39'h00_0040_0000, 100, 10);
    n_cmp++; if (obs_done_cyc != 18) begin n_fail++; $display("FAIL busy_start_done_cycle: got %0d required 18", obs_done_cyc); end
    n_cmp++; if (n_writes != 17) begin n_fail++; $display("FAIL busy_start_write_count: got %0d required 17", n_writes); end
    n_cmp++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL busy_start_missing_writes: got %0d left required 0", exp_q.size()); end
  endtask

  task automatic test_back_to_back();
    run_boot(2, 6'd5, 39'h00_0000_8000, 100, 0);
    n_cmp++; if (obs_done_c1 !== 1'b0) begin n_fail++; $display("FAIL b2b_done_cleared: got %b required 0", obs_done_c1); end
    n_cmp++; if (obs_done_cyc != 12) begin n_fail++; $display("FAIL b2b_done_cycle: got %0d required 12", obs_done_cyc); end
    n_cmp++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL b2b_missing_writes: got %0d left required 0", exp_q.size()); end
  endtask

  task automatic test_reset_mid();
    drive_inputs(6, 6'd11, 39'h00_1234_0000);
    n_writes    = 0;
    cfg_ready_i = 1'b1;
    start_i     = 1'b1;
    @(posedge clk);
    #1;
    start_i = 1'b0;
    for (int c = 1; c < 4; c++) begin
      @(negedge clk);
      @(posedge clk);
      #1;
    end
    reset_i     = 1'b1;
    cfg_ready_i = 1'b0;
    @(negedge clk);
    n_cmp++; if (cfg_addr_o !== 16'h0008) begin n_fail++; $display("FAIL rmid_in_cord: got addr %h required 0008", cfg_addr_o); end
    @(posedge clk);
    #1;
    reset_i = 1'b0;
    @(negedge clk);
    n_cmp++; if (cfg_v_o !== 1'b0) begin n_fail++; $display("FAIL rmid_valid: got %b required 0", cfg_v_o); end
    n_cmp++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL rmid_busy: got %b required 0", busy_o); end
    n_cmp++; if (done_o !== 1'b0) begin n_fail++; $display("FAIL rmid_done: got %b required 0", done_o); end
    n_cmp++; if (n_writes != 3) begin n_fail++; $display("FAIL rmid_writes_before_reset: got %0d required 3", n_writes); end
    exp_q.delete();
    @(posedge clk);
    #1;
    run_boot(3, 6'd12, 39'h00_0000_4000, 100, 0);
    n_cmp++; if (obs_done_cyc != 13) begin n_fail++; $display("FAIL rmid_rerun_done_cycle: got %0d required 13", obs_done_cyc); end
    n_cmp++; if (n_writes != 12) begin n_fail++; $display("FAIL rmid_rerun_write_count: got %0d required 12", n_writes); end
    n_cmp++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL rmid_rerun_missing_writes: got %0d left required 0", exp_q.size()); end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    n_cmp         = 0;
    n_fail        = 0;
    n_writes      = 0;
    saw_ucode     = 1'b0;
    rom_salt      = 32'hC0DE_5A17;
    reset_i       = 1'b1;
    start_i       = 1'b0;
    boot_pc_i     = '0;
    core_id_i     = '0;
    did_i         = '0;
    cord_i        = '0;
    icache_mode_i = '0;
    dcache_mode_i = '0;
    cce_mode_i    = 1'b0;
    ucode_len_i   = '0;
    cfg_ready_i   = 1'b0;

    test_reset();
    test_basic();
    test_len_zero();
    test_stalls();
    rom_salt = 32'h1357_9BDF;
    test_saturate();
    test_start_while_busy();
    test_back_to_back();
    test_reset_mid();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
